// File: rtl/sm_input_debounce_pkg.sv
// Shared defaults and sizing helpers for the board-input debouncer.
package sm_input_debounce_pkg;

    localparam int unsigned SM_DEBOUNCE_WIDTH        = 12;
    localparam int unsigned SM_DEBOUNCE_PRESCALE     = 50000;
    localparam int unsigned SM_DEBOUNCE_STABLE_TICKS = 20;
    localparam logic [11:0] SM_DEBOUNCE_INVERT       = 12'h003;

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_debounce_bit.sv
// One input bit: polarity fix, 2-flop synchroniser, stability counter, level and edge pulses.
module sm_debounce_bit
    import sm_input_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = SM_DEBOUNCE_STABLE_TICKS,
    parameter logic        INVERT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic tick,
    output logic db_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = width_for(STABLE_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in ^ INVERT;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any return to the accepted level restarts qualification from zero.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/sm_input_debounce.sv
// Board-input conditioner: shared tick prescaler plus one debounce slice per pin.
module sm_input_debounce
    import sm_input_debounce_pkg::*;
#(
    parameter int unsigned       WIDTH        = SM_DEBOUNCE_WIDTH,
    parameter logic [WIDTH-1:0]  INVERT       = WIDTH'(SM_DEBOUNCE_INVERT),
    parameter int unsigned       PRESCALE     = SM_DEBOUNCE_PRESCALE,
    parameter int unsigned       STABLE_TICKS = SM_DEBOUNCE_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned PW = width_for(PRESCALE);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // Free-running 0..PRESCALE-1; the wrap cycle is the debounce tick.
    always_comb begin
        tick_c = (pcnt_q == PW'(PRESCALE - 1));
        pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .INVERT       (INVERT[i])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw_in (raw_in[i]),
            .tick   (tick_c),
            .db_out (db_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign changed = |(rise | fall);

endmodule

// File: tb/tb_sm_input_debounce.sv
// Scoreboard bench for sm_input_debounce with WIDTH=4, PRESCALE=4, STABLE_TICKS=3.
module tb_sm_input_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'b0011;
    logic [3:0] db_out, rise, fall;
    logic       changed;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] db;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_db = 4'b0000;

    sm_input_debounce #(
        .WIDTH        (4),
        .INVERT       (4'b0011),
        .PRESCALE     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .db_out  (db_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Step to just after the next rising edge; returns its cycle number.
    task automatic step(output int c);
        @(posedge clk);
        #1;
        c = cyc;
    endtask

    task automatic wait_cycles(input int n);
        int c;
        for (int i = 0; i < n; i++) step(c);
    endtask

    // Expected pulse: db visible 2 sync + 9..12 cycles after the input edge at cycle c.
    task automatic expect_change(input logic [3:0] r, input logic [3:0] f, input int c);
        exp_t e;
        exp_db = (exp_db | r) & ~f;
        e.rise = r;
        e.fall = f;
        e.db   = exp_db;
        e.lo   = c + 11;
        e.hi   = c + 14;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("changed_vs_pulses", 32'(changed), 32'(|(rise | fall)));
        check("rise_fall_overlap", 32'(rise & fall), 32'h0);
        if (rst) begin
            check("reset_outputs", {20'h0, db_out, rise, fall}, 32'h0);
        end else if ((rise | fall) != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {24'h0, rise, fall}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("pulse_rise", 32'(rise), 32'(e.rise));
                check("pulse_fall", 32'(fall), 32'(e.fall));
                check("pulse_db", 32'(db_out), 32'(e.db));
                check("pulse_not_early", 32'(cyc >= e.lo), 32'h1);
                check("pulse_not_late", 32'(cyc <= e.hi), 32'h1);
            end
        end else if (sb.size() > 0 && cyc > sb[0].hi) begin
            check("pulse_timeout", 32'(cyc), 32'(sb[0].hi));
            void'(sb.pop_front());
        end
    end

    initial begin
        int c;

        // 1: reset with idle keys, then 100 quiet cycles
        wait_cycles(3);
        check("reset_db", 32'(db_out), 32'h0);
        rst = 1'b0;
        wait_cycles(100);
        check("idle_db", 32'(db_out), 32'h0);

        // 2: press KEY0 and hold
        step(c);
        raw_in[0] = 1'b0;
        expect_change(4'b0001, 4'b0000, c);
        wait_cycles(40);
        check("key0_held_db", 32'(db_out), 32'h1);

        // 3: short glitch on SW2 must be rejected
        step(c);
        raw_in[2] = 1'b1;
        wait_cycles(6);
        raw_in[2] = 1'b0;
        wait_cycles(30);
        check("glitch_db", 32'(db_out), 32'h1);

        // 4: SW3 bounces every 3 cycles, settles high on the last toggle
        for (int i = 0; i < 13; i++) begin
            step(c);
            raw_in[3] = ~raw_in[3];
            wait_cycles(2);
        end
        expect_change(4'b1000, 4'b0000, c);
        wait_cycles(30);
        check("bounce_db", 32'(db_out), 32'h9);

        // 5: KEY1 press and SW2 on in the same cycle
        step(c);
        raw_in[1] = 1'b0;
        raw_in[2] = 1'b1;
        expect_change(4'b0110, 4'b0000, c);
        wait_cycles(30);
        check("simul_db", 32'(db_out), 32'hf);

        // 6: release KEY0, re-press, reset mid-qualification
        step(c);
        raw_in[0] = 1'b1;
        expect_change(4'b0000, 4'b0001, c);
        wait_cycles(30);
        check("key0_release_db", 32'(db_out), 32'he);
        step(c);
        raw_in[0] = 1'b0;
        wait_cycles(5);
        rst = 1'b1;
        exp_db = 4'b0000;
        #1;
        check("rst_async_db", 32'(db_out), 32'h0);
        wait_cycles(3);
        check("queue_empty_at_rst", 32'(sb.size()), 32'h0);
        step(c);
        rst = 1'b0;
        expect_change(4'b1111, 4'b0000, c);
        wait_cycles(30);
        check("requal_db", 32'(db_out), 32'hf);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
